ad_buff_fifo: RTL and testbench



---
 rtl/ad_buff_fifo.sv | 173 +++++++++++++++++
 tb/tb_ad_buff_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ad_buff_fifo.sv
// ad_buff_fifo
//   ADC capture front end. A rising edge on i_st starts a capture of
//   i_recv_count dual-sample words. Two consecutive samples are packed as
//   {first, second} and pushed into an internal single-clock FIFO, which the
//   readout logic drains through i_rd_req / o_dual_data.
// Ports
//   i_ad_clk      clock (ADC sample clock and FIFO read clock)
//   i_rst         synchronous active-high reset
//   i_st          capture request (rising edge only, ignored while busy)
//   i_recv_count  number of dual words to capture, latched at start
//   i_ad_data     one ADC sample per clock
//   i_rd_req      FIFO read request
//   o_dual_data   registered FIFO read data
//   o_rd_empty    registered FIFO empty flag
//   o_full        registered FIFO full flag
//   o_working     high while a capture is in progress
//   o_overflow    sticky: a word was dropped on a full FIFO
module ad_buff_fifo #(
  parameter int AD_DATA_SIZE    = 8,
  parameter int FIFO_ADDR_WIDTH = 9
) (
  input  logic                      i_ad_clk,
  input  logic                      i_rst,
  input  logic                      i_st,
  input  logic [15:0]               i_recv_count,
  input  logic [AD_DATA_SIZE-1:0]   i_ad_data,
  input  logic                      i_rd_req,
  output logic [2*AD_DATA_SIZE-1:0] o_dual_data,
  output logic                      o_rd_empty,
  output logic                      o_full,
  output logic                      o_working,
  output logic                      o_overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int WW    = 2 * AD_DATA_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_START, S_COLLECT, S_END} state_t;

  state_t state_reg, state_next;

  logic              st_prev_reg;
  logic [15:0]       count_reg;
  logic [15:0]       cnt_reg;
  logic              phase_reg;
  logic [AD_DATA_SIZE-1:0] hi_reg;
  logic [WW-1:0]     word_reg;
  logic              wr_en_reg;
  logic              working_reg;

  // Decoded controls from the FSM
  logic start_edge;
  logic latch_count;
  logic clear_count;
  logic sample_en;

  assign start_edge = i_st && !st_prev_reg;

  // State register
  always_ff @(posedge i_ad_clk) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start_edge) state_next = S_START;
      S_START:   state_next = (count_reg == 16'd0) ? S_END : S_COLLECT;
      S_COLLECT: if (phase_reg && (cnt_reg + 16'd1 == count_reg)) state_next = S_END;
      S_END:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    latch_count = 1'b0;
    clear_count = 1'b0;
    sample_en   = 1'b0;
    case (state_reg)
      S_IDLE:    latch_count = start_edge;
      S_START:   clear_count = 1'b1;
      S_COLLECT: sample_en   = 1'b1;
      default:   ;
    endcase
  end

  // Capture datapath
  always_ff @(posedge i_ad_clk) begin
    if (i_rst) begin
      // Reset counts i_st as already high, so a level held through reset
      // release is not mistaken for a new request.
      st_prev_reg <= 1'b1;
      count_reg   <= '0;
      cnt_reg     <= '0;
      phase_reg   <= 1'b0;
      hi_reg      <= '0;
      word_reg    <= '0;
      wr_en_reg   <= 1'b0;
      working_reg <= 1'b0;
    end else begin
      st_prev_reg <= i_st;
      wr_en_reg   <= 1'b0;
      // Registered from the next state so o_working lines up with state_reg
      working_reg <= (state_next != S_IDLE);
      if (latch_count) count_reg <= i_recv_count;
      if (clear_count) begin
        cnt_reg   <= '0;
        phase_reg <= 1'b0;
      end
      if (sample_en) begin
        phase_reg <= ~phase_reg;
        if (!phase_reg) begin
          hi_reg <= i_ad_data;
        end else begin
          word_reg  <= {hi_reg, i_ad_data};
          wr_en_reg <= 1'b1;
          cnt_reg   <= cnt_reg + 16'd1;
        end
      end
    end
  end

  assign o_working = working_reg;

  // FIFO
  logic [WW-1:0]            mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr_reg, rd_ptr_reg;
  logic                     fifo_empty, fifo_full, rd_ok, wr_ok;
  logic                     empty_reg, full_reg, overflow_reg;
  logic [WW-1:0]            rd_data_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FIFO_ADDR_WIDTH-1:0] == rd_ptr_reg[FIFO_ADDR_WIDTH-1:0]) &&
                      (wr_ptr_reg[FIFO_ADDR_WIDTH] != rd_ptr_reg[FIFO_ADDR_WIDTH]);
  assign rd_ok      = i_rd_req && !fifo_empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle
  assign wr_ok      = wr_en_reg && (!fifo_full || rd_ok);

  always_ff @(posedge i_ad_clk) begin
    if (wr_ok) mem[wr_ptr_reg[FIFO_ADDR_WIDTH-1:0]] <= word_reg;
  end

  always_ff @(posedge i_ad_clk) begin
    if (i_rst)      rd_data_reg <= '0;
    else if (rd_ok) rd_data_reg <= mem[rd_ptr_reg[FIFO_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge i_ad_clk) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en_reg && !wr_ok) overflow_reg <= 1'b1;
      // Flags follow the pointers one cycle after they move
      empty_reg <= fifo_empty;
      full_reg  <= fifo_full;
    end
  end

  assign o_dual_data = rd_data_reg;
  assign o_rd_empty  = empty_reg;
  assign o_full      = full_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_ad_buff_fifo.sv
// Directed bench for ad_buff_fifo: one default-depth instance and one
// 4-word instance share all inputs; the small one exercises full/overflow.
module tb_ad_buff_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [15:0] recv_count;
    logic [7:0]  ad_data;
    logic        rd_req;

    logic [15:0] dual_data, dual_data_s;
    logic        rd_empty, rd_empty_s;
    logic        full, full_s;
    logic        working, working_s;
    logic        overflow, overflow_s;

    int tests = 0;
    int fails = 0;
    int hi_cycles;
    bit done = 1'b0;

    always #5 clk = ~clk;

    ad_buff_fifo #(.AD_DATA_SIZE(8), .FIFO_ADDR_WIDTH(9)) dut (
        .i_ad_clk(clk), .i_rst(rst), .i_st(st), .i_recv_count(recv_count),
        .i_ad_data(ad_data), .i_rd_req(rd_req), .o_dual_data(dual_data),
        .o_rd_empty(rd_empty), .o_full(full), .o_working(working), .o_overflow(overflow)
    );

    ad_buff_fifo #(.AD_DATA_SIZE(8), .FIFO_ADDR_WIDTH(2)) dut_s (
        .i_ad_clk(clk), .i_rst(rst), .i_st(st), .i_recv_count(recv_count),
        .i_ad_data(ad_data), .i_rd_req(rd_req), .o_dual_data(dual_data_s),
        .o_rd_empty(rd_empty_s), .o_full(full_s), .o_working(working_s), .o_overflow(overflow_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] PASS %s: %0h", tag, obs);
        end
    endtask

    initial begin
        #100us;
        if (!done) begin
            fails++;
            $error("FAIL timeout: bench did not finish in time");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic capture(input logic [15:0] n, input logic [7:0] base, output int hi);
        hi = 0;
        @(negedge clk);
        st = 1'b1;
        recv_count = n;
        for (int k = 1; k <= 2 * n + 5; k++) begin
            @(negedge clk);
            if (working) hi++;
            if (k == 3) recv_count = 16'd1;
            if (k >= 2 && k <= 2 * n + 1) ad_data = base + 8'(k - 2);
            else ad_data = 8'h00;
        end
        $display("[TB] capture n=%0d base=%h working_cycles=%0d", n, base, hi);
    endtask

    task automatic read_word(output logic [15:0] d, output logic [15:0] ds);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        d  = dual_data;
        ds = dual_data_s;
        $display("[TB] read data=%h small=%h", d, ds);
    endtask

    logic [15:0] d, ds;

    initial begin
        rst = 1'b1; st = 1'b1; recv_count = 16'd3; ad_data = 8'h00; rd_req = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_data", dual_data, 16'h0000);
        check("rst_empty", rd_empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_working", working, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        hi_cycles = 0;
        repeat (5) begin
            @(negedge clk);
            if (working) hi_cycles++;
        end
        check("st_high_at_release", hi_cycles, 0);

        st = 1'b0;
        capture(16'd3, 8'h01, hi_cycles);
        check("cap3_working", hi_cycles, 8);
        check("cap3_not_empty", rd_empty, 1'b0);
        read_word(d, ds);
        check("cap3_w0", d, 16'h0102);
        read_word(d, ds);
        check("cap3_w1", d, 16'h0304);
        read_word(d, ds);
        check("cap3_w2", d, 16'h0506);
        repeat (2) @(negedge clk);
        check("cap3_empty", rd_empty, 1'b1);
        read_word(d, ds);
        check("read_empty_holds", d, 16'h0506);

        hi_cycles = 0;
        repeat (4) begin
            @(negedge clk);
            if (working) hi_cycles++;
        end
        check("st_held_no_restart", hi_cycles, 0);

        st = 1'b0;
        capture(16'd0, 8'h00, hi_cycles);
        check("cap0_working", hi_cycles, 2);
        check("cap0_empty", rd_empty, 1'b1);

        st = 1'b0;
        capture(16'd6, 8'h11, hi_cycles);
        st = 1'b0;
        check("cap6_working", hi_cycles, 14);
        check("small_full", full_s, 1'b1);
        check("small_overflow", overflow_s, 1'b1);
        check("big_not_full", full, 1'b0);
        check("big_no_overflow", overflow, 1'b0);
        read_word(d, ds);
        check("small_w0", ds, 16'h1112);
        check("big_w0", d, 16'h1112);
        read_word(d, ds);
        check("small_w1", ds, 16'h1314);
        read_word(d, ds);
        check("small_w2", ds, 16'h1516);
        read_word(d, ds);
        check("small_w3", ds, 16'h1718);
        check("big_w3", d, 16'h1718);
        repeat (2) @(negedge clk);
        check("small_drained", rd_empty_s, 1'b1);
        check("small_not_full", full_s, 1'b0);
        check("big_remaining", rd_empty, 1'b0);

        @(negedge clk);
        st = 1'b1;
        recv_count = 16'd3;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ad_data = 8'h51 + 8'(k);
        end
        @(negedge clk);
        check("mid_working", working, 1'b1);
        rst = 1'b1;
        st  = 1'b0;
        @(negedge clk);
        check("abort_working", working, 1'b0);
        check("abort_empty", rd_empty, 1'b1);
        check("abort_overflow", overflow_s, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        capture(16'd2, 8'hA1, hi_cycles);
        check("recap_working", hi_cycles, 6);
        read_word(d, ds);
        check("recap_w0", d, 16'hA1A2);
        read_word(d, ds);
        check("recap_w1", d, 16'hA3A4);
        repeat (2) @(negedge clk);
        check("recap_empty", rd_empty, 1'b1);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
